// File: rtl/pid_pwm_driver.sv
// ----------------------------------------------------------------------------
// pid_pwm_driver
//
// Output stage of the PID controller. Takes the signed 64-bit control word,
// arithmetic-shifts and clamps its magnitude to a duty count, and drives a
// complementary, edge-aligned PWM gate pair with dead-time. The sign of the
// command is exported as dir for H-bridge direction.
//
// Duty updates are double-buffered. A command is first captured into a
// shadow register. It is then copied into the active register at the last
// cycle of each period. While the block is disabled, the copy happens on
// every cycle.
//
// Ports
//   clk          system clock
//   rstn         synchronous reset, active-low
//   en           1 = run PWM, 0 = gates off and counter held at 0
//   ctrl_in      signed control word from the PID stage
//   ctrl_valid   single-cycle strobe qualifying ctrl_in
//   pwm_h        high-side gate drive (registered)
//   pwm_l        low-side gate drive (registered)
//   dir          sign of the active command (1 = negative)
//   duty         active duty count for the current period
//   sat          active duty was clamped to PERIOD
//   period_done  one-cycle pulse following the last cycle of each period
// ----------------------------------------------------------------------------
module pid_pwm_driver #(
    parameter int CNT_W    = 16,
    parameter int PERIOD   = 2500,
    parameter int SHIFT    = 8,
    parameter int DEADTIME = 25
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [63:0]      ctrl_in,
    input  logic             ctrl_valid,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic             dir,
    output logic [CNT_W-1:0] duty,
    output logic             sat,
    output logic             period_done
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DUTY_MAX  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] DT_LAST   = CNT_W'((DEADTIME > 0) ? DEADTIME - 1 : 0);
    localparam bit               NO_DT     = (DEADTIME == 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        H_ON  = 3'd1,
        DT_HL = 3'd2,
        L_ON  = 3'd3,
        DT_LH = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Command scaling and clamping (combinational, captured on ctrl_valid)
    // ------------------------------------------------------------------
    logic signed [63:0] shifted;
    logic [63:0]        shifted_u;
    logic [63:0]        mag;
    logic               cap_dir;
    logic               cap_sat;
    logic [CNT_W-1:0]   cap_duty;

    always_comb begin
        shifted   = $signed(ctrl_in) >>> SHIFT;
        shifted_u = shifted;
        cap_dir   = shifted_u[63];
        // The two's complement of the most-negative value is 2**63.
        // Read as unsigned, this is still a correct magnitude, so the
        // unsigned compare below clamps it without overflow.
        mag       = cap_dir ? (~shifted_u + 64'd1) : shifted_u;
        cap_sat   = (mag > 64'(PERIOD));
        cap_duty  = cap_sat ? DUTY_MAX : mag[CNT_W-1:0];
    end

    // ------------------------------------------------------------------
    // Shadow and active duty registers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] shadow_duty_reg;
    logic             shadow_dir_reg;
    logic             shadow_sat_reg;
    logic [CNT_W-1:0] duty_reg;
    logic             dir_reg;
    logic             sat_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             period_done_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shadow_duty_reg <= '0;
            shadow_dir_reg  <= 1'b0;
            shadow_sat_reg  <= 1'b0;
        end else if (ctrl_valid) begin
            shadow_duty_reg <= cap_duty;
            shadow_dir_reg  <= cap_dir;
            shadow_sat_reg  <= cap_sat;
        end
    end

    // The active copy reads the shadow value from before this edge. A
    // strobe on the boundary cycle therefore waits one full period.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            duty_reg <= '0;
            dir_reg  <= 1'b0;
            sat_reg  <= 1'b0;
        end else if (!en || (cnt_reg == CNT_LAST)) begin
            duty_reg <= shadow_duty_reg;
            dir_reg  <= shadow_dir_reg;
            sat_reg  <= shadow_sat_reg;
        end
    end

    // ------------------------------------------------------------------
    // Period counter and boundary pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_reg         <= '0;
            period_done_reg <= 1'b0;
        end else begin
            period_done_reg <= en && (cnt_reg == CNT_LAST);
            if (!en || (cnt_reg == CNT_LAST)) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Raw edge-aligned PWM request before dead-time shaping.
    logic raw;
    assign raw = en && (cnt_reg < duty_reg);

    // ------------------------------------------------------------------
    // Gate FSM with dead-time
    // ------------------------------------------------------------------
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] dt_reg;
    logic [CNT_W-1:0] dt_next;
    logic             pwm_h_reg;
    logic             pwm_l_reg;

    always_comb begin
        state_next = state_reg;
        // The dead-time counter restarts whenever a dead-time state is
        // entered or left. It only advances while the FSM waits in one.
        dt_next    = '0;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (raw) state_next = NO_DT ? H_ON : DT_LH;
                    else     state_next = NO_DT ? L_ON : DT_HL;
                end
                H_ON: begin
                    if (!raw) state_next = NO_DT ? L_ON : DT_HL;
                end
                DT_HL: begin
                    if (raw)                     state_next = H_ON;
                    else if (dt_reg == DT_LAST)  state_next = L_ON;
                    else                         dt_next    = dt_reg + 1'b1;
                end
                L_ON: begin
                    if (raw) state_next = NO_DT ? H_ON : DT_LH;
                end
                DT_LH: begin
                    // A request shorter than the dead-time falls back to
                    // L_ON here, so the high side never sees a runt pulse.
                    if (!raw)                    state_next = L_ON;
                    else if (dt_reg == DT_LAST)  state_next = H_ON;
                    else                         dt_next    = dt_reg + 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // The gate outputs are decoded from the next state and then registered.
    // This keeps them glitch-free and aligned with the state register. Only
    // one state drives each gate, so both gates can never be on together.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
            dt_reg    <= '0;
            pwm_h_reg <= 1'b0;
            pwm_l_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            dt_reg    <= dt_next;
            pwm_h_reg <= (state_next == H_ON);
            pwm_l_reg <= (state_next == L_ON);
        end
    end

    assign pwm_h       = pwm_h_reg;
    assign pwm_l       = pwm_l_reg;
    assign dir         = dir_reg;
    assign duty        = duty_reg;
    assign sat         = sat_reg;
    assign period_done = period_done_reg;

endmodule
